// File: rtl/seg7_scan_display.sv
// 8-bit binary to 3-digit BCD (sequential double-dabble) driving a multiplexed
// common-anode 7-segment display. Define SEG7_LEAD_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_display #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        valid
);

    localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [19:0]      shift_q, shift_d;
    logic [7:0]       last_q, last_d;
    logic             first_q, first_d;
    logic [2:0]       step_q, step_d;
    logic [11:0]      bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic [3:0]       digit;
    logic             blank;

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble step over {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] t;
        t = {adj3(r[19:16]), adj3(r[15:12]), adj3(r[11:8]), r[7:0]};
        return t << 1;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        first_d = first_q;
        step_d  = step_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (first_q || (value != last_q)) begin
                    shift_d = {12'h000, value};
                    last_d  = value;
                    first_d = 1'b0;
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = dabble_step(shift_q);
                step_d  = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = shift_q[19:8];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Output registers sample the current index, so the pins lag the index by one cycle.
    always_comb begin
        digit = bcd_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                digit = bcd_q[7:4];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                digit = bcd_q[11:8];
`ifdef SEG7_LEAD_ZERO_BLANK_EN
                blank = (bcd_q[11:8] == 4'd0);
`endif
            end
            default: digit = bcd_q[3:0];
        endcase
        an_d  = ~(3'b001 << idx_q);
        seg_d = blank ? 7'h7F : decode(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            last_q  <= '0;
            first_q <= 1'b1;
            step_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 3'b111;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            first_q <= first_d;
            step_q  <= step_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign bcd   = bcd_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: reference model plus conversion scoreboard, driven by directed vectors.
module tb_seg7_scan_display;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  value = 8'd255;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        busy;
    logic        valid;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    int          exp_cyc_q[$];

    // Reference model state (reset values).
    int          cyc     = 0;
    int          m_cnt   = 0;
    int          m_div   = 0;
    int          m_idx   = 0;
    logic        m_first = 1'b1;
    logic        m_valid = 1'b0;
    logic [7:0]  m_last  = 8'd0;
    logic [11:0] m_bcd   = 12'h000;
    logic [6:0]  m_seg   = 7'h7F;
    logic [2:0]  m_an    = 3'b111;

    seg7_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .busy  (busy),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int n;
        n = int'(v);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [11:0] b, input int idx);
        if (idx == 1) begin
`ifdef SEG7_LEAD_ZERO_BLANK_EN
            if (b[11:8] == 4'd0 && b[7:4] == 4'd0) return 7'h7F;
`endif
            return seg_of(b[7:4]);
        end
        if (idx == 2) begin
`ifdef SEG7_LEAD_ZERO_BLANK_EN
            if (b[11:8] == 4'd0) return 7'h7F;
`endif
            return seg_of(b[11:8]);
        end
        return seg_of(b[3:0]);
    endfunction

    // Reference model: pushes an expected conversion whenever a value is sampled.
    initial begin
        logic [11:0] junk_b;
        int          junk_c;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                if (m_cnt != 0) begin
                    junk_b = exp_q.pop_back();
                    junk_c = exp_cyc_q.pop_back();
                end
                m_cnt   = 0;
                m_first = 1'b1;
                m_valid = 1'b0;
                m_bcd   = 12'h000;
                m_div   = 0;
                m_idx   = 0;
                m_seg   = 7'h7F;
                m_an    = 3'b111;
            end else begin
                cyc++;
                m_an  = ~(3'b001 << m_idx);
                m_seg = digit_seg(m_bcd, m_idx);
                if (m_div == int'(SCAN_DIV) - 1) begin
                    m_div = 0;
                    m_idx = (m_idx == 2) ? 0 : m_idx + 1;
                end else begin
                    m_div++;
                end
                if (m_cnt == 0) begin
                    if (m_first || value != m_last) begin
                        m_first = 1'b0;
                        m_last  = value;
                        m_cnt   = 9;
                        exp_q.push_back(to_bcd(value));
                        exp_cyc_q.push_back(cyc + 9);
                    end
                end else begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_bcd   = to_bcd(m_last);
                        m_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle output compare; scoreboard pop whenever a conversion completes.
    initial begin
        logic        prev_busy;
        logic [11:0] eb;
        int          ec;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            check("an", 32'(an), 32'(m_an));
            check("seg", 32'(seg), 32'(m_seg));
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("valid", 32'(valid), 32'(m_valid));
            check("bcd_hold", 32'(bcd), 32'(m_bcd));
            if (reset && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got bcd %0h expected no completion at %0t", bcd, $time);
                end else begin
                    eb = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("sb_bcd", 32'(bcd), 32'(eb));
                    check("sb_latency", 32'(cyc), 32'(ec));
                end
            end
            prev_busy = reset ? busy : 1'b0;
        end
    end

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n;
        n = 0;
        while (busy !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'(lvl));
    endtask

    task automatic capture_digits(output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
        s0 = 'x;
        s1 = 'x;
        s2 = 'x;
        repeat (3 * SCAN_DIV + 1) begin
            @(negedge clk);
            case (an)
                3'b110:  s0 = seg;
                3'b101:  s1 = seg;
                3'b011:  s2 = seg;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [6:0] s0, s1, s2;
        logic       up;

        // Reset held with value 255 present.
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'b111);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        #2 reset = 1'b1;

        @(negedge clk);
        check("first_an", 32'(an), 32'b110);
        check("first_seg", 32'(seg), 32'h40);
        check("first_busy", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        check("edge9_valid", 32'(valid), 32'd0);
        check("edge9_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("bcd_255", 32'(bcd), 32'h255);
        check("valid_255", 32'(valid), 32'd1);
        check("busy_255", 32'(busy), 32'd0);

        // 255 -> 100 while idle.
        value = 8'd100;
        @(negedge clk);
        check("busy_rise_100", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        check("bcd_100", 32'(bcd), 32'h100);
        repeat (2) @(negedge clk);
        capture_digits(s0, s1, s2);
        check("d100_ones", 32'(s0), 32'h40);
        check("d100_tens", 32'(s1), 32'h40);
        check("d100_hund", 32'(s2), 32'h79);

        // Value 7: leading zeros shown or blanked.
        value = 8'd7;
        wait_busy(1'b1, 3, "start_7");
        wait_busy(1'b0, 20, "done_7");
        check("bcd_007", 32'(bcd), 32'h007);
        repeat (2) @(negedge clk);
        capture_digits(s0, s1, s2);
        check("d7_ones", 32'(s0), 32'h78);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        check("d7_tens", 32'(s1), 32'h7F);
        check("d7_hund", 32'(s2), 32'h7F);
`else
        check("d7_tens", 32'(s1), 32'h40);
        check("d7_hund", 32'(s2), 32'h40);
`endif

        // 10 -> 20 three cycles into a conversion.
        value = 8'd10;
        wait_busy(1'b1, 3, "start_10");
        repeat (2) @(negedge clk);
        value = 8'd20;
        wait_busy(1'b0, 20, "done_10");
        check("bcd_010", 32'(bcd), 32'h010);
        wait_busy(1'b1, 3, "start_20");
        wait_busy(1'b0, 20, "done_20");
        check("bcd_020", 32'(bcd), 32'h020);

        // Reset during the fourth shift step.
        value = 8'd200;
        wait_busy(1'b1, 3, "start_200");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an", 32'(an), 32'b111);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_bcd", 32'(bcd), 32'h000);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        wait_busy(1'b1, 3, "restart_200");
        wait_busy(1'b0, 20, "done_200");
        check("bcd_200", 32'(bcd), 32'h200);

        // Free-running up/down counter.
        up = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i % 53 == 0) up = ~up;
            value = up ? value + 8'd1 : value - 8'd1;
        end
        repeat (25) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("valid_final", 32'(valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
